// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: pops a FIFO into a 2-entry skid buffer and streams words out with burst markers.
// Optional pop counter on rd_count enabled by defining FIFO_STREAM_READER_CNT_EN.
module fifo_stream_reader #(
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             empty_fifo,
  output logic             read_en,
  input  logic [WIDTH-1:0] fifo_data,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             idle,
  output logic [CNT_W-1:0] rd_count
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t           state;
  logic [1:0]       occ;
  logic             inflight;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [BW-1:0]    beat_cnt;
  logic             xfer;
  logic             cap;

  // occ + inflight bounds the skid buffer, so a captured word always has a slot.
  assign read_en = (state == FETCH) && empty_fifo &&
                   (({1'b0, occ} + {2'b00, inflight}) < 3'd2);
  assign m_valid = (occ != 2'd0);
  assign m_data  = head_q;
  assign m_last  = m_valid && (beat_cnt == LAST_BEAT);
  assign idle    = (occ == 2'd0) && !inflight && !read_en;
  assign xfer    = m_valid && m_ready;
  assign cap     = inflight;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      occ      <= 2'd0;
      inflight <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE:    if (enable) state <= FETCH;
        FETCH:   if (!enable) state <= DRAIN;
        DRAIN: begin
          if (enable)                             state <= FETCH;
          else if (occ == 2'd0 && !inflight)      state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      inflight <= read_en;
      occ      <= occ + {1'b0, cap} - {1'b0, xfer};

      // Head is the output register; tail only holds a word while the head is stalled.
      case ({cap, xfer})
        2'b10: begin
          if (occ == 2'd0) head_q <= fifo_data;
          else             tail_q <= fifo_data;
        end
        2'b01: begin
          if (occ == 2'd2) head_q <= tail_q;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head_q <= fifo_data;
          end else begin
            head_q <= tail_q;
            tail_q <= fifo_data;
          end
        end
        default: ;
      endcase

      if (xfer) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
    end
  end

`ifdef FIFO_STREAM_READER_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst)         cnt_q <= '0;
    else if (read_en) cnt_q <= cnt_q + 1'b1;
  end

  assign rd_count = cnt_q;
`else
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: behavioural FIFO, expected-word queue and a negedge monitor.
module tb_fifo_stream_reader;
  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        empty_fifo;
  logic        read_en;
  logic [31:0] fifo_data = '0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic        idle;
  logic [31:0] rd_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:4095];
  int wp = 0;
  int rp = 0;
  int base = 0;
  int exp_idx[$];

  fifo_stream_reader #(.WIDTH(32), .BURST_LEN(BL), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .enable(enable), .empty_fifo(empty_fifo),
    .read_en(read_en), .fifo_data(fifo_data), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .idle(idle), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  assign empty_fifo = (wp != rp);

  // Behavioural FIFO: data appears the cycle after a pop.
  always @(posedge clk) begin
    if (read_en && wp != rp) begin
      fifo_data <= mem[rp];
      rp <= rp + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] v);
    mem[wp] = v;
    exp_idx.push_back(wp);
    wp++;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every transfer must match the next expected word and burst position.
  int unsigned mbeats = 0;
  logic        stalled = 1'b0;
  logic [31:0] held_data;
  logic        held_last;
  always @(negedge clk) begin
    int idx;
    if (!rst) begin
      mbeats = 0;
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, held_data);
        chk("stall_last", m_last, held_last);
      end
      if (!m_valid) chk("last_gated", m_last, 0);
      if (m_valid && m_ready) begin
        if (exp_idx.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          idx = exp_idx.pop_front();
          chk("beat_data", m_data, mem[idx]);
          chk("beat_last", m_last, ((mbeats % BL) == BL - 1) ? 1 : 0);
        end
        mbeats++;
      end
      stalled = m_valid && !m_ready;
      held_data = m_data;
      held_last = m_last;
    end
  end

  // Wait until every popped word is delivered and the block is idle (and the FIFO empty if full).
  task automatic wait_quiet(input bit full, input string nm);
    int n = 0;
    while (!((exp_idx.size() == wp - rp) && idle && (!full || wp == rp)) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) chk(nm, 0, 1);
    next();
  endtask

  function automatic logic [31:0] exp_count(input int c);
`ifdef FIFO_STREAM_READER_CNT_EN
    return 32'(c);
`else
    return 32'd0 + 32'(c & 0);
`endif
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    int n;
    int pops;
    repeat (3) next();
    @(negedge clk);
    chk("rst_read_en", read_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_idle", idle, 1);
    chk("rst_rd_count", rd_count, 0);
    next();
    rst = 1'b1;

    // Four-word burst with latency check.
    m_ready = 1'b1;
    enable = 1'b1;
    push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
    n = 0;
    @(negedge clk);
    while (!read_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("first_pop_seen", (n < 10) ? 1 : 0, 1);
    @(negedge clk);
    chk("lat_n1_valid", m_valid, 0);
    @(negedge clk);
    chk("lat_n2_valid", m_valid, 1);
    chk("lat_n2_data", m_data, 32'h11);
    wait_quiet(1, "burst4_timeout");

    // Stall: 8 words, consumer blocked for 10 cycles.
    m_ready = 1'b0;
    push_word(32'hA0); push_word(32'hA1); push_word(32'hA2); push_word(32'hA3);
    push_word(32'hA4); push_word(32'hA5); push_word(32'hA6); push_word(32'hA7);
    pops = 0;
    repeat (10) begin
      @(negedge clk);
      if (read_en) pops++;
      next();
    end
    chk("stall_pops", pops, 2);
    @(negedge clk);
    chk("stall_head_valid", m_valid, 1);
    chk("stall_head_data", m_data, 32'hA0);
    next();
    m_ready = 1'b1;
    wait_quiet(1, "stall_drain_timeout");

    // Empty FIFO: no pops, idle held.
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (read_en || !idle) n++;
      next();
    end
    chk("empty_no_pop_idle", n, 0);
    push_word(32'hA5);
    wait_quiet(1, "single_timeout");

    // Enable dropped the cycle after the first pop.
    m_ready = 1'b0;
    push_word(32'hB0); push_word(32'hB1); push_word(32'hB2); push_word(32'hB3); push_word(32'hB4);
    @(negedge clk);
    chk("drop_first_pop", read_en, 1);
    next();
    enable = 1'b0;
    next();
    pops = 0;
    repeat (6) begin
      @(negedge clk);
      if (read_en) pops++;
      next();
    end
    m_ready = 1'b1;
    n = 0;
    while (!(idle && exp_idx.size() == wp - rp) && n < 100) begin
      @(negedge clk);
      if (read_en) pops++;
      n++;
    end
    chk("drop_no_new_pops", pops, 0);
    chk("drop_left_in_fifo", wp - rp, 3);
    repeat (3) begin
      @(negedge clk);
      if (read_en) pops++;
    end
    chk("drop_idle", idle, 1);
    chk("drop_still_no_pops", pops, 0);
    next();
    enable = 1'b1;
    wait_quiet(1, "drop_drain_timeout");

    // Reset with a full skid buffer.
    m_ready = 1'b0;
    push_word(32'hC0); push_word(32'hC1); push_word(32'hC2);
    repeat (5) next();
    @(negedge clk);
    chk("pre_rst_valid", m_valid, 1);
    next();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_read_en", read_en, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_last", m_last, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_idle", idle, 1);
    chk("mid_rst_rd_count", rd_count, 0);
    while (exp_idx.size() != 0 && exp_idx[0] < rp) void'(exp_idx.pop_front());
    base = rp;
    chk("rst_leftover", wp - rp, 1);
    next();
    rst = 1'b1;

    // 300 pops since reset: the leftover word plus 299 more.
    m_ready = 1'b1;
    for (int i = 0; i < 299; i++) push_word($urandom);
    wait_quiet(1, "pop300_timeout");
    @(negedge clk);
    chk("rd_count_300", rd_count, exp_count(300));
    next();

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && wp < 4000) push_word($urandom);
      next();
    end
    enable = 1'b1;
    m_ready = 1'b1;
    wait_quiet(1, "random_drain_timeout");
    @(negedge clk);
    chk("final_idle", idle, 1);
    chk("final_scoreboard_empty", exp_idx.size(), 0);
    chk("final_rd_count", rd_count, exp_count(wp - base));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
